uart_sim_monitor: RTL
=====================

// Module: uart_sim_monitor
// PURPOSE
//   Simulation-side consumer of the MCU uart_tx line in the Verilator bench. Decodes 8N1 frames at
//   the MCU baud rate and buffers received bytes in a FIFO drained by a valid/ready port. Also
//   detects the end-of-test sequence written by firmware: 0x04 followed by an exit-code byte.
// PARAMETERS
//   CLOCK_FREQUENCY  50000000  clock frequency in Hz; must match the MCU setting
//   UART_BAUD_RATE   9600      line rate in baud; CYCLES_PER_BIT = CLOCK_FREQUENCY/UART_BAUD_RATE (integer)
//   FIFO_DEPTH       16        receive FIFO entries; power of two, >= 2
// PORTS
//   clock          input   1  single clock for all logic
//   reset          input   1  synchronous, active-high reset
//   uart_rx        input   1  serial line; connected to the MCU uart_tx; idle high
//   byte_data      output  8  FIFO head byte; valid only while byte_valid=1
//   byte_valid     output  1  FIFO non-empty
//   byte_ready     input   1  consumer accepts the head; pop when byte_valid & byte_ready
//   overflow       output  1  sticky: a good byte was dropped because the FIFO was full
//   framing_error  output  1  one-cycle pulse: stop bit sampled low
//   parity_error   output  1  one-cycle pulse: parity mismatch (tied 0 without the macro)
//   exit_valid     output  1  sticky: end-of-test sequence received
//   exit_code      output  8  byte following 0x04; held while exit_valid=1
// BEHAVIOUR
//   - Reset: all outputs 0; FIFO emptied; FSM to IDLE; exit detector disarmed; synchroniser flops set to 1.
//   - uart_rx passes through a 2-flop synchroniser; all decoding uses the synchronised value.
//   - FSM IDLE: a synchronised low starts frame -> START, bit counter loaded with CYCLES_PER_BIT/2.
//   - START: at count expiry sample; high = glitch -> IDLE, no flag; low -> DATA, counter = CYCLES_PER_BIT.
//   - DATA: sample every CYCLES_PER_BIT; 8 bits LSB first into a shift register -> STOP (or PARITY).
//   - STOP: sample after CYCLES_PER_BIT. High = good byte: push, then -> IDLE in the same cycle.
//     Low = pulse framing_error, discard byte -> WAIT_IDLE; WAIT_IDLE -> IDLE once the line is high.
//   - Push: byte_valid rises on the cycle after the stop-bit sample; the FIFO is first-word fall-through.
//   - Full FIFO with a good byte and no pop: byte dropped, overflow set (cleared only by reset).
//   - Full FIFO with push and pop on the same cycle: both occur, no overflow.
//   - Empty FIFO with push: byte is not bypassed; it appears next cycle. Pointers wrap modulo FIFO_DEPTH.
//   - Exit detector sees every good byte, independent of FIFO state. Good byte 0x04 arms it. The next
//     good byte, any value including 0x04, is latched into exit_code; exit_valid is set on that push cycle.
//     After exit_valid the detector is frozen. Exit bytes are also written to the FIFO.
//   - A framing or parity error between 0x04 and the code byte disarms the detector.
//   - Reset mid-frame aborts the frame; no partial byte is pushed and no flag is raised.
// CONFIGURATION
//   UART_SIM_MONITOR_PARITY_EN defined: a PARITY state follows DATA and samples one even-parity bit
//     CYCLES_PER_BIT later. A mismatch pulses parity_error and discards the byte; the FSM still checks
//     the stop bit, then -> IDLE or WAIT_IDLE. A framing error takes precedence, with one pulse only.
//   Not defined: 8N1 only; no PARITY state; parity_error held at 0.
// TESTING (CLOCK_FREQUENCY=1000000, UART_BAUD_RATE=100000 -> 10 cycles/bit, FIFO_DEPTH=4)
//   - Send 0x55 with byte_ready=0 -> byte_valid=1 with byte_data=0x55 one cycle after the stop sample;
//     no error flags.
//   - Send 0x41,0x42,0x43,0x44,0x45 with byte_ready=0 -> overflow=1; draining yields 0x41..0x44 only.
//   - Send 0x41 with its stop bit driven low -> one framing_error pulse, FIFO stays empty, next 0x42 received.
//   - 3-cycle low glitch on an idle line -> no byte and no flag; FSM back in IDLE.
//   - Send 0x04,0x2A -> exit_valid=1, exit_code=0x2A; later 0x04,0x00 leaves exit_code=0x2A.
//   - PARITY_EN: 0x03 with parity bit 1 -> parity_error pulse, no push; with parity bit 0 -> accepted.

Source files
------------

// File: rtl/uart_sim_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : uart_sim_monitor
//  Purpose  : Bench-side UART receiver for the MCU tx line. Decodes 8N1 frames
//             into a first-word fall-through FIFO and detects the firmware
//             end-of-test sequence (0x04 followed by an exit-code byte).
//             Define UART_SIM_MONITOR_PARITY_EN to add one even-parity bit.
//  Revision : 1.0  initial release
// ============================================================================

module uart_sim_monitor #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int UART_BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       overflow,
    output logic       framing_error,
    output logic       parity_error,
    output logic       exit_valid,
    output logic [7:0] exit_code
);

    localparam int c_CYCLES_PER_BIT = CLOCK_FREQUENCY / UART_BAUD_RATE;
    localparam int c_CNT_W          = $clog2(c_CYCLES_PER_BIT + 1);
    localparam int c_PTR_W          = $clog2(FIFO_DEPTH);

    localparam logic [c_CNT_W-1:0] c_CNT_FULL  = c_CNT_W'(c_CYCLES_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_CNT_HALF  = c_CNT_W'(c_CYCLES_PER_BIT / 2);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]   c_COUNT_ONE = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W:0]   c_FIFO_FULL = (c_PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_START     = 3'd1;
    localparam logic [2:0] c_ST_DATA      = 3'd2;
`ifdef UART_SIM_MONITOR_PARITY_EN
    localparam logic [2:0] c_ST_PARITY    = 3'd3;
`endif
    localparam logic [2:0] c_ST_STOP      = 3'd4;
    localparam logic [2:0] c_ST_WAIT_IDLE = 3'd5;

    logic               r_sync_meta;
    logic               r_sync_rx;
    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_framing_error;

    logic w_rx;
    logic w_tick;
    logic w_timed;
    logic w_load_half;
    logic w_shift_en;
    logic w_stop_sample;
    logic w_good;
    logic w_ferr;
    logic w_perr;

`ifdef UART_SIM_MONITOR_PARITY_EN
    logic r_par_bad;
    logic r_parity_error;
    logic w_par_sample;
`endif

    logic [7:0]         r_mem [0:FIFO_DEPTH-1];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               r_overflow;
    logic               w_full;
    logic               w_pop;
    logic               w_write;

    logic               r_armed;
    logic               r_exit_valid;
    logic [7:0]         r_exit_code;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync_meta <= 1'b1;
            r_sync_rx   <= 1'b1;
        end else begin
            r_sync_meta <= uart_rx;
            r_sync_rx   <= r_sync_meta;
        end
    end

    assign w_rx   = r_sync_rx;
    assign w_tick = (r_cnt == c_CNT_ONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_rx) w_state_next = c_ST_START;
            end
            c_ST_START: begin
                if (w_tick) w_state_next = w_rx ? c_ST_IDLE : c_ST_DATA;
            end
            c_ST_DATA: begin
`ifdef UART_SIM_MONITOR_PARITY_EN
                if (w_tick && (r_bit_idx == 3'd7)) w_state_next = c_ST_PARITY;
`else
                if (w_tick && (r_bit_idx == 3'd7)) w_state_next = c_ST_STOP;
`endif
            end
`ifdef UART_SIM_MONITOR_PARITY_EN
            c_ST_PARITY: begin
                if (w_tick) w_state_next = c_ST_STOP;
            end
`endif
            c_ST_STOP: begin
                if (w_tick) w_state_next = w_rx ? c_ST_IDLE : c_ST_WAIT_IDLE;
            end
            c_ST_WAIT_IDLE: begin
                if (w_rx) w_state_next = c_ST_IDLE;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_timed       = 1'b0;
        w_load_half   = 1'b0;
        w_shift_en    = 1'b0;
        w_stop_sample = 1'b0;
`ifdef UART_SIM_MONITOR_PARITY_EN
        w_par_sample  = 1'b0;
`endif
        case (r_state)
            c_ST_IDLE:  w_load_half = !w_rx;
            c_ST_START: w_timed     = 1'b1;
            c_ST_DATA: begin
                w_timed    = 1'b1;
                w_shift_en = w_tick;
            end
`ifdef UART_SIM_MONITOR_PARITY_EN
            c_ST_PARITY: begin
                w_timed      = 1'b1;
                w_par_sample = w_tick;
            end
`endif
            c_ST_STOP: begin
                w_timed       = 1'b1;
                w_stop_sample = w_tick;
            end
            default: ;
        endcase
        // A low stop bit outranks a parity mismatch so only one pulse fires
        w_ferr = w_stop_sample & !w_rx;
`ifdef UART_SIM_MONITOR_PARITY_EN
        w_perr = w_stop_sample & w_rx & r_par_bad;
        w_good = w_stop_sample & w_rx & !r_par_bad;
`else
        w_perr = 1'b0;
        w_good = w_stop_sample & w_rx;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt           <= '0;
            r_bit_idx       <= 3'd0;
            r_shift         <= 8'h00;
            r_framing_error <= 1'b0;
        end else begin
            if (w_load_half) begin
                r_cnt <= c_CNT_HALF;
            end else if (w_timed) begin
                r_cnt <= w_tick ? c_CNT_FULL : (r_cnt - c_CNT_ONE);
            end
            if (w_load_half) begin
                r_bit_idx <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_shift_en) begin
                r_shift <= {w_rx, r_shift[7:1]};
            end
            r_framing_error <= w_ferr;
        end
    end

`ifdef UART_SIM_MONITOR_PARITY_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_par_bad      <= 1'b0;
            r_parity_error <= 1'b0;
        end else begin
            if (w_load_half) begin
                r_par_bad <= 1'b0;
            end else if (w_par_sample) begin
                r_par_bad <= w_rx ^ (^r_shift);
            end
            r_parity_error <= w_perr;
        end
    end

    assign parity_error = r_parity_error;
`else
    assign parity_error = 1'b0;
`endif

    assign framing_error = r_framing_error;

    // Receive FIFO: a pop frees the slot for a same-cycle push when full
    assign w_full  = (r_count == c_FIFO_FULL);
    assign w_pop   = byte_valid & byte_ready;
    assign w_write = w_good & (!w_full | w_pop);

    always_ff @(posedge clock) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + c_COUNT_ONE;
                2'b01:   r_count <= r_count - c_COUNT_ONE;
                default: ;
            endcase
            if (w_good && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign byte_valid = (r_count != '0);
    assign byte_data  = byte_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign overflow   = r_overflow;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_armed      <= 1'b0;
            r_exit_valid <= 1'b0;
            r_exit_code  <= 8'h00;
        end else if (!r_exit_valid) begin
            if (w_good) begin
                if (r_armed) begin
                    r_exit_code  <= r_shift;
                    r_exit_valid <= 1'b1;
                end else if (r_shift == 8'h04) begin
                    r_armed <= 1'b1;
                end
            end else if (w_ferr || w_perr) begin
                r_armed <= 1'b0;
            end
        end
    end

    assign exit_valid = r_exit_valid;
    assign exit_code  = r_exit_code;

endmodule

`default_nettype wire
